hazard_scheduler: RTL and testbench

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler_pkg.sv | 58 +++++
 rtl/hazard_scheduler_sat.sv | 21 ++
 rtl/hazard_scheduler.sv | 132 +++++++++++++
 tb/tb_hazard_scheduler.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
// Purpose: shared pipeline control types: per-stage control bundles, flow
//   flags, hazard scheduler state enum and the NOP selection behind id_bubble.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package hazard_scheduler_pkg;

  // Control bundles that ID hands to ID/EX.
  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } id_ctrl_t;

  // Per-register flow request: hold contents or squash them.
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_flow_t;

  // Hazard scheduler states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } sched_state_e;

  // An all-zero bundle never writes memory or the register file, so it is a NOP.
  localparam id_ctrl_t NOP_CTRL = '0;

  // id_bubble selects the NOP bundles in place of the decoded ones.
  function automatic id_ctrl_t select_id_ctrl(input logic id_bubble, input id_ctrl_t decoded);
    return id_bubble ? NOP_CTRL : decoded;
  endfunction

  // A load in EX feeding a source of the instruction in ID; x0 never creates a hazard.
  function automatic logic load_use_hazard(input logic       ex_mem_read,
                                           input logic [4:0] ex_rd_addr,
                                           input logic [4:0] id_rs1_addr,
                                           input logic [4:0] id_rs2_addr);
    return ex_mem_read && (ex_rd_addr != 5'd0) &&
           ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));
  endfunction

endpackage

// File: rtl/hazard_scheduler_sat.sv
// Purpose: saturating up-counter; sticks at all-ones instead of wrapping.
// Latency: count reflects inc one clock later. Backpressure: none.
// Ports: clk, reset (async, active-low), inc (count this cycle), count.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Purpose: pipeline hazard scheduler: memory freeze, branch flush, load-use stall, perf counters.
// Latency: stall/flush outputs are combinational (zero cycle); counters and mem_timeout are registered.
// Backpressure: a pending data access (dmem_req without dmem_ready) freezes the whole pipeline.
// Ports: clk; reset (async, active-low); id_rs1_addr/id_rs2_addr, ex_rd_addr, ex_mem_read,
//   ex_branch_taken, dmem_req, dmem_ready in; pc_stall, if_id_stall, id_bubble, if_id_flush,
//   id_ex_flush, ex_mem_stall, mem_wb_stall, mem_timeout, stall_cycles, flush_events out.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        ex_rd_addr,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_wb_stall,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  sched_state_e     state, next_state;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             mem_freeze;
  logic             hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_nxt;
      // Sticky: only reset clears it, even after the access completes.
      if (next_state == TIMEOUT) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state   = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        // A ready with no request is ignored; a same-cycle ready never freezes.
        if (dmem_req && !dmem_ready) begin
          next_state   = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          next_state = RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if (wait_cnt == WAIT_LAST) begin
            next_state = TIMEOUT;
          end
        end
      end
      TIMEOUT: begin
        if (dmem_ready) begin
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // The freeze covers the completing cycle too; the pipeline moves on the following edge.
  assign mem_freeze = ((state == RUN) && dmem_req && !dmem_ready) || (state != RUN);
  assign hazard     = load_use_hazard(ex_mem_read, ex_rd_addr, id_rs1_addr, id_rs2_addr);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_bubble    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    // reset is active-low: nothing is requested while it is held.
    if (reset) begin
      if (mem_freeze) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (ex_branch_taken) begin
        // The instruction in ID is on the wrong path, so its hazard is moot.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_bubble   = 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_id_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Purpose: directed-vector bench with a scoreboard queue checked by an independent monitor.
// Latency: one vector per clock, checked on the falling edge of the same cycle.
// Backpressure: n/a.
module tb_hazard_scheduler;

  // Expected flag order: {pc_stall, if_id_stall, id_bubble, if_id_flush,
  //                       id_ex_flush, ex_mem_stall, mem_wb_stall, mem_timeout}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] STL  = 8'b1110_0000;
  localparam logic [7:0] FLS  = 8'b0001_1000;
  localparam logic [7:0] FRZ  = 8'b1100_0110;
  localparam logic [7:0] TO   = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       pc_stall, if_id_stall, id_bubble, if_id_flush, id_ex_flush;
  logic       ex_mem_stall, mem_wb_stall, mem_timeout;
  logic [3:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  hazard_scheduler #(.MEM_TIMEOUT(4), .PERF_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .ex_rd_addr      (ex_rd_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_bubble       (id_bubble),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_stall    (mem_wb_stall),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  // Apply one cycle of inputs just after the rising edge and queue what that cycle must show.
  task automatic row(input string nm, input logic rst,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic mr, input logic br, input logic req, input logic rdy,
                     input logic [7:0] fl, input logic [3:0] sc, input logic [3:0] fe);
    @(posedge clk);
    #1;
    reset           = rst;
    id_rs1_addr     = rs1;
    id_rs2_addr     = rs2;
    ex_rd_addr      = rd;
    ex_mem_read     = mr;
    ex_branch_taken = br;
    dmem_req        = req;
    dmem_ready      = rdy;
    exp_q.push_back({fl, sc, fe});
    name_q.push_back(nm);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      logic [15:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pc_stall, if_id_stall, id_bubble, if_id_flush, id_ex_flush,
           ex_mem_stall, mem_wb_stall, mem_timeout, stall_cycles, flush_events};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b stall_cycles=%0d flush_events=%0d, want flags=%b stall_cycles=%0d flush_events=%0d",
                 n, a[15:8], a[7:4], a[3:0], e[15:8], e[7:4], e[3:0]);
      end
    end
  end

  initial begin
    //   name            rst rs1 rs2 rd mr br req rdy flags     sc  fe
    row("rst_idle",      0,  0,  0,  0, 0, 0, 0,  0,  NONE,     0,  0);
    row("rst_gate",      0,  0,  5,  5, 1, 1, 1,  0,  NONE,     0,  0);
    row("idle",          1,  0,  0,  0, 0, 0, 0,  0,  NONE,     0,  0);
    row("lu_rs2",        1,  3,  5,  5, 1, 0, 0,  0,  STL,      0,  0);
    row("lu_one_cycle",  1,  3,  5,  5, 0, 0, 0,  0,  NONE,     1,  0);
    row("lu_rd0",        1,  0,  0,  0, 1, 0, 0,  0,  NONE,     1,  0);
    row("lu_rs1",        1,  7,  2,  7, 1, 0, 0,  0,  STL,      1,  0);
    row("no_load",       1,  7,  2,  7, 0, 0, 0,  0,  NONE,     2,  0);
    row("br_over_lu",    1,  0,  5,  5, 1, 1, 0,  0,  FLS,      2,  0);
    row("br_count",      1,  0,  0,  0, 0, 0, 0,  0,  NONE,     2,  1);
    row("zero_cyc_acc",  1,  0,  0,  0, 0, 0, 1,  1,  NONE,     2,  1);
    row("rdy_no_req",    1,  0,  0,  0, 0, 0, 0,  1,  NONE,     2,  1);
    row("rst_clr_cnt",   0,  0,  0,  0, 0, 0, 0,  0,  NONE,     0,  0);
    // Three cycles without ready, then ready: four freeze cycles.
    row("frz_over_br",   1,  0,  5,  5, 1, 1, 1,  0,  FRZ,      0,  0);
    row("wait1",         1,  0,  0,  0, 0, 0, 1,  0,  FRZ,      1,  0);
    row("wait2",         1,  0,  0,  0, 0, 0, 1,  0,  FRZ,      2,  0);
    row("wait_done",     1,  0,  0,  0, 0, 0, 1,  1,  FRZ,      3,  0);
    row("back_run",      1,  0,  0,  0, 0, 0, 0,  0,  NONE,     4,  0);
    // Ready held low: timeout flag appears after the fifth freeze cycle.
    for (int i = 0; i < 5; i++)
      row("to_wait",     1,  0,  0,  0, 0, 0, 1,  0,  FRZ,      4'(4 + i), 0);
    row("to_set",        1,  0,  0,  0, 0, 0, 1,  0,  FRZ | TO, 9,  0);
    row("to_hold",       1,  0,  0,  0, 0, 0, 1,  0,  FRZ | TO, 10, 0);
    row("to_exit",       1,  0,  0,  0, 0, 0, 1,  1,  FRZ | TO, 11, 0);
    row("to_sticky",     1,  0,  0,  0, 0, 0, 0,  0,  TO,       12, 0);
    // Stalls 13..20 since the last reset; the 4-bit counter stops at 15.
    for (int i = 0; i < 8; i++)
      row("sat",         1,  5,  0,  5, 1, 0, 0,  0,  STL | TO, (i > 3) ? 4'd15 : 4'(12 + i), 0);
    row("sat_hold",      1,  0,  0,  0, 0, 0, 0,  0,  TO,       15, 0);
    row("enter_wait",    1,  0,  0,  0, 0, 0, 1,  0,  FRZ | TO, 15, 0);
    // Reset dropped mid-cycle in MEM_WAIT: everything clears before any edge.
    row("async_rst",     0,  0,  5,  5, 1, 1, 1,  0,  NONE,     0,  0);
    row("rst_to_run",    1,  0,  0,  0, 0, 0, 0,  0,  NONE,     0,  0);
    row("br2",           1,  0,  0,  0, 0, 1, 0,  0,  FLS,      0,  0);
    row("br3",           1,  0,  0,  0, 0, 1, 0,  0,  FLS,      0,  1);
    row("fe_count",      1,  0,  0,  0, 0, 0, 0,  0,  NONE,     0,  2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
